// File: rtl/arb412_pkg.sv
// Shared types and constants for the arb412 four-way round-robin arbiter.
package arb412_pkg;
    localparam int WIDTH_DEF = 12;
    localparam int N_REQ     = 4;

    typedef logic [1:0] idx_t;

    function automatic logic [N_REQ-1:0] onehot4(input idx_t idx);
        return 4'b0001 << idx;
    endfunction
endpackage

// File: rtl/arb412_rr_pick4.sv
// Round-robin pick: first set bit of e_i scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick4
    import arb412_pkg::*;
(
    input  logic [N_REQ-1:0] e_i,
    input  idx_t             ptr_i,
    output logic [N_REQ-1:0] win_o,
    output idx_t             idx_o,
    output logic             any_o
);
    idx_t cand;

    always_comb begin
        idx_o = ptr_i;
        any_o = 1'b0;
        cand  = ptr_i;
        // Walk from the farthest offset down so the nearest eligible slot wins last.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr_i + idx_t'(k);
            if (e_i[cand]) begin
                idx_o = cand;
                any_o = 1'b1;
            end
        end
        win_o = any_o ? onehot4(idx_o) : '0;
    end
endmodule

// File: rtl/arb412.sv
// Four-requester round-robin arbiter with a single registered output word
// (y/s/valid) and valid/ready handshake downstream.
module arb412
    import arb412_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [3:0]       mask,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       gnt,
    output logic [WIDTH-1:0] y,
    output logic [1:0]       s,
    output logic             valid,
    input  logic             ready
);
    logic [WIDTH-1:0] y_q, y_d;
    idx_t             s_q, s_d;
    idx_t             ptr_q, ptr_d;
    logic             valid_q, valid_d;
    logic             armed_q;

    logic [3:0] elig;
    logic [3:0] win;
    idx_t       win_idx;
    logic       any;
    logic       load;
    logic [WIDTH-1:0] mux_data;

    assign elig = req & mask;

    rr_pick4 u_pick (
        .e_i   (elig),
        .ptr_i (ptr_q),
        .win_o (win),
        .idx_o (win_idx),
        .any_o (any)
    );

    // armed_q keeps gnt quiet between reset release and the first clock edge.
    assign load = armed_q & any & (~valid_q | ready);
    assign gnt  = load ? win : 4'b0000;

    always_comb begin
        case (win_idx)
            2'd0:    mux_data = d0;
            2'd1:    mux_data = d1;
            2'd2:    mux_data = d2;
            default: mux_data = d3;
        endcase
    end

    always_comb begin
        y_d     = y_q;
        s_d     = s_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        if (load) begin
            y_d     = mux_data;
            s_d     = win_idx;
            ptr_d   = win_idx + 2'd1;
            valid_d = 1'b1;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_q     <= '0;
            s_q     <= 2'd0;
            ptr_q   <= 2'd0;
            valid_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            s_q     <= s_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            armed_q <= 1'b1;
        end
    end

    assign y     = y_q;
    assign s     = s_q;
    assign valid = valid_q;
endmodule

// File: tb/tb_arb412.sv
// Directed, table-driven bench for arb412 plus hand sequences for reset corners.
module tb_arb412;
    localparam int W = 12;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req, mask, gnt;
    logic [W-1:0] d0, d1, d2, d3, y;
    logic [1:0]   s;
    logic         valid, ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    arb412 #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .mask  (mask),
        .d0    (d0),
        .d1    (d1),
        .d2    (d2),
        .d3    (d3),
        .gnt   (gnt),
        .y     (y),
        .s     (s),
        .valid (valid),
        .ready (ready)
    );

    typedef struct {
        logic [3:0]   req;
        logic [3:0]   mask;
        logic         ready;
        logic [3:0]   gnt;
        logic         valid;
        logic [W-1:0] y;
        logic [1:0]   s;
    } vec_t;

    vec_t vt[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] eg, input logic ev,
                           input logic [W-1:0] ey, input logic [1:0] es);
        chk({tag, ".gnt"},   32'(gnt),   32'(eg));
        chk({tag, ".valid"}, 32'(valid), 32'(ev));
        chk({tag, ".y"},     32'(y),     32'(ey));
        chk({tag, ".s"},     32'(s),     32'(es));
    endtask

    initial begin
        // req, mask, ready | expected gnt (same cycle), valid, y, s (state before the edge)
        vt[0]  = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 12'h000, 2'd0};
        vt[1]  = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b0, 12'h000, 2'd0};
        vt[2]  = '{4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 12'h000, 2'd0};
        vt[3]  = '{4'hF, 4'hF, 1'b1, 4'h4, 1'b1, 12'h111, 2'd1};
        vt[4]  = '{4'hF, 4'hF, 1'b1, 4'h8, 1'b1, 12'h222, 2'd2};
        vt[5]  = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 12'h333, 2'd3};
        vt[6]  = '{4'h5, 4'hF, 1'b0, 4'h0, 1'b1, 12'h000, 2'd0};
        vt[7]  = '{4'h5, 4'hF, 1'b0, 4'h0, 1'b1, 12'h000, 2'd0};
        vt[8]  = '{4'h5, 4'hF, 1'b1, 4'h4, 1'b1, 12'h000, 2'd0};
        vt[9]  = '{4'h3, 4'hF, 1'b1, 4'h1, 1'b1, 12'h222, 2'd2};
        vt[10] = '{4'h3, 4'hF, 1'b1, 4'h2, 1'b1, 12'h000, 2'd0};
        vt[11] = '{4'hF, 4'hA, 1'b1, 4'h8, 1'b1, 12'h111, 2'd1};
        vt[12] = '{4'hF, 4'hA, 1'b1, 4'h2, 1'b1, 12'h333, 2'd3};
        vt[13] = '{4'hF, 4'hA, 1'b1, 4'h8, 1'b1, 12'h111, 2'd1};
        vt[14] = '{4'hF, 4'hA, 1'b1, 4'h2, 1'b1, 12'h333, 2'd3};
        vt[15] = '{4'h0, 4'hF, 1'b1, 4'h0, 1'b1, 12'h111, 2'd1};
        vt[16] = '{4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 12'h111, 2'd1};
        vt[17] = '{4'h4, 4'hF, 1'b1, 4'h4, 1'b0, 12'h111, 2'd1};
        vt[18] = '{4'h0, 4'hF, 1'b1, 4'h0, 1'b1, 12'h222, 2'd2};
        vt[19] = '{4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 12'h222, 2'd2};
        vt[20] = '{4'h1, 4'hE, 1'b1, 4'h0, 1'b0, 12'h222, 2'd2};
        vt[21] = '{4'h0, 4'hF, 1'b0, 4'h0, 1'b0, 12'h222, 2'd2};

        reset = 1'b1;
        req   = 4'hF;
        mask  = 4'hF;
        ready = 1'b1;
        d0 = 12'h000; d1 = 12'h111; d2 = 12'h222; d3 = 12'h333;

        #2;
        chk_all("reset_state", 4'h0, 1'b0, 12'h000, 2'd0);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 22; i++) begin
            req   = vt[i].req;
            mask  = vt[i].mask;
            ready = vt[i].ready;
            #1;
            chk_all($sformatf("row%0d", i), vt[i].gnt, vt[i].valid, vt[i].y, vt[i].s);
            @(negedge clk);
        end

        // First load ignores ready, then the word is held until ready returns.
        reset = 1'b1;
        #1;
        chk_all("rst2", 4'h0, 1'b0, 12'h000, 2'd0);
        @(negedge clk);
        reset = 1'b0; req = 4'h5; mask = 4'hF; ready = 1'b0;
        #1;
        chk("stall.unarmed_gnt", 32'(gnt), 32'h0);
        @(negedge clk);
        #1;
        chk_all("stall.first", 4'h1, 1'b0, 12'h000, 2'd0);
        @(negedge clk);
        #1;
        chk_all("stall.hold1", 4'h0, 1'b1, 12'h000, 2'd0);
        @(negedge clk);
        #1;
        chk_all("stall.hold2", 4'h0, 1'b1, 12'h000, 2'd0);
        ready = 1'b1;
        #1;
        chk("stall.release_gnt", 32'(gnt), 32'h4);
        @(negedge clk);
        req = 4'h0;
        #1;
        chk_all("stall.next", 4'h0, 1'b1, 12'h222, 2'd2);

        // Async reset while a word is held discards it immediately.
        d3 = 12'hABC; req = 4'h8; ready = 1'b1;
        #1;
        chk("abc.gnt", 32'(gnt), 32'h8);
        @(negedge clk);
        ready = 1'b0;
        #1;
        chk_all("abc.held", 4'h0, 1'b1, 12'hABC, 2'd3);
        #1;
        reset = 1'b1;
        #1;
        chk_all("midrst", 4'h0, 1'b0, 12'h000, 2'd0);
        @(negedge clk);
        reset = 1'b0; ready = 1'b1; req = 4'h8;
        #1;
        chk("postrst.unarmed_gnt", 32'(gnt), 32'h0);
        @(negedge clk);
        #1;
        chk_all("postrst.first", 4'h8, 1'b0, 12'h000, 2'd0);
        @(negedge clk);
        req = 4'hA;
        #1;
        chk_all("postrst.load", 4'h2, 1'b1, 12'hABC, 2'd3);
        @(negedge clk);
        req = 4'h0;
        #1;
        chk_all("postrst.wrap", 4'h0, 1'b1, 12'h111, 2'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
